// File: rtl/vga_fb_write_arbiter_pkg.sv
// vga_fb_write_arbiter_pkg: screen geometry, pixel codes and fill FSM states
package vga_fb_write_arbiter_pkg;
    localparam int HD = 1280;
    localparam int VD = 1024;
    localparam int COORD_BITS = 11;
    localparam int COLOR_BITS = 2;
    typedef logic [COORD_BITS-1:0] coord_t;
    typedef enum logic [COLOR_BITS-1:0] {WHITE, BLACK, GREEN, RED} color_t;
    typedef enum logic [1:0] {IDLE, CHECK, FILL} fill_state_t;
    function automatic coord_t clamp(input coord_t v, input int lim);
        return (int'(v) > lim - 1) ? coord_t'(lim - 1) : v;
    endfunction
endpackage

// File: rtl/vga_fb_write_arbiter_if.sv
// vga_fb_write_arbiter_if: host pixel stream, fill command and frame-buffer write port
interface vga_fb_write_arbiter_if;
    import vga_fb_write_arbiter_pkg::*;
    logic px_valid_i, px_ready_o;
    coord_t px_x_i, px_y_i;
    logic [COLOR_BITS-1:0] px_color_i;
    logic fill_valid_i, fill_ready_o;
    coord_t fill_x0_i, fill_y0_i, fill_x1_i, fill_y1_i;
    logic [COLOR_BITS-1:0] fill_color_i;
    logic fill_abort_i, fill_busy_o, fill_done_o;
    logic we_o;
    coord_t addr_x_o, addr_y_o;
    logic [COLOR_BITS-1:0] color_o;
    modport master (
        output px_valid_i, px_x_i, px_y_i, px_color_i,
        output fill_valid_i, fill_x0_i, fill_y0_i, fill_x1_i, fill_y1_i, fill_color_i, fill_abort_i,
        input  px_ready_o, fill_ready_o, fill_busy_o, fill_done_o, we_o, addr_x_o, addr_y_o, color_o
    );
    modport slave (
        input  px_valid_i, px_x_i, px_y_i, px_color_i,
        input  fill_valid_i, fill_x0_i, fill_y0_i, fill_x1_i, fill_y1_i, fill_color_i, fill_abort_i,
        output px_ready_o, fill_ready_o, fill_busy_o, fill_done_o, we_o, addr_x_o, addr_y_o, color_o
    );
endinterface

// File: rtl/vga_fb_write_arbiter_rr.sv
// vga_fb_write_arbiter_rr: two-requester round-robin arbiter, one-hot grant
module vga_fb_write_arbiter_rr (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       prio_o
);
    always_comb begin
        gnt_o[0] = req_i[0] && (!req_i[1] || !prio_o);
        gnt_o[1] = req_i[1] && (!req_i[0] || prio_o);
    end
    always_ff @(posedge clk_i or posedge arst_i)
        if (arst_i) prio_o <= 1'b0;
        else if (|req_i) prio_o <= gnt_o[0];
endmodule

// File: rtl/vga_fb_write_arbiter.sv
// vga_fb_write_arbiter: shares the frame-buffer write port between host pixels and a rectangle-fill engine
module vga_fb_write_arbiter
    import vga_fb_write_arbiter_pkg::*;
(
    input logic clk_i,
    input logic arst_i,
    vga_fb_write_arbiter_if.slave bus
);
    fill_state_t state, state_n;
    coord_t x0, y0, x1, y1, cx, cy, x1c, y1c;
    logic [COLOR_BITS-1:0] fcolor;
    logic fill_req, last_px, empty, px_in, prio;
    logic [1:0] gnt;

    vga_fb_write_arbiter_rr u_rr (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .req_i  ({fill_req, bus.px_valid_i}),
        .gnt_o  (gnt),
        .prio_o (prio)
    );

    always_comb begin
        fill_req = state == FILL && !bus.fill_abort_i;
        x1c = clamp(x1, HD);
        y1c = clamp(y1, VD);
        empty = x0 > x1c || y0 > y1c;
        last_px = cx == x1 && cy == y1;
        px_in = int'(bus.px_x_i) < HD && int'(bus.px_y_i) < VD;
        bus.px_ready_o = !(fill_req && prio);
        bus.fill_ready_o = state == IDLE;
        bus.fill_busy_o = state != IDLE;
        state_n = state == IDLE  ? (bus.fill_valid_i ? CHECK : IDLE) :
                  state == CHECK ? (empty ? IDLE : FILL) :
                  (bus.fill_abort_i || (gnt[1] && last_px)) ? IDLE : FILL;
    end

    always_ff @(posedge clk_i or posedge arst_i)
        if (arst_i) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            {x0, y0, x1, y1, cx, cy} <= '0;
            fcolor <= '0;
            bus.we_o <= 1'b0;
            bus.fill_done_o <= 1'b0;
            bus.addr_x_o <= '0;
            bus.addr_y_o <= '0;
            bus.color_o <= '0;
        end else begin
            bus.fill_done_o <= (state == CHECK && empty) || (gnt[1] && last_px);
            bus.we_o <= gnt[1] || (gnt[0] && px_in);
            if (gnt[1]) begin
                bus.addr_x_o <= cx;
                bus.addr_y_o <= cy;
                bus.color_o <= fcolor;
                cx <= cx == x1 ? x0 : cx + 1'b1;
                cy <= cx == x1 ? cy + 1'b1 : cy;
            end else if (gnt[0]) begin
                bus.addr_x_o <= bus.px_x_i;
                bus.addr_y_o <= bus.px_y_i;
                bus.color_o <= bus.px_color_i;
            end
            if (bus.fill_valid_i && state == IDLE) begin
                x0 <= bus.fill_x0_i;
                y0 <= bus.fill_y0_i;
                x1 <= bus.fill_x1_i;
                y1 <= bus.fill_y1_i;
                fcolor <= bus.fill_color_i;
            end
            if (state == CHECK) begin
                x1 <= x1c;
                y1 <= y1c;
                cx <= x0;
                cy <= y0;
            end
        end
    end
endmodule
